// File: rtl/mfp_ahb_arbiter.sv
// mfp_ahb_arbiter
//
// Two-master AHB-Lite arbiter. It shares one slave path between the MIPS core
// (master 0) and a secondary bus master (master 1).
//
// The address-phase owner and the data-phase owner are tracked separately, so
// a handover is pipelined: the outgoing master's data phase runs in the same
// cycle as the incoming master's address phase.
//
// Arbitration is round-robin. A burst cap forces re-arbitration when the other
// master is waiting.
//
// Ports:
//   clk_in    - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   m_req     - per-master bus request (bit i = master i)
//   m_haddr   - {m1, m0} addresses
//   m_hwdata  - {m1, m0} write data
//   m_hwrite  - per-master HWRITE
//   m_hsize   - {m1, m0} HSIZE
//   m_htrans  - {m1, m0} HTRANS
//   m_grant   - one-hot address-phase ownership
//   m_hready  - per-master HREADY (0 stalls a master that owns neither phase)
//   m_hrdata  - read data, broadcast to both masters
//   s_*       - muxed slave-path address/control/write data, and the
//               slave-path HREADY/HRDATA inputs
module mfp_ahb_arbiter #(
    parameter int MAX_BURST      = 16,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [1:0]  m_req,
    input  logic [63:0] m_haddr,
    input  logic [63:0] m_hwdata,
    input  logic [1:0]  m_hwrite,
    input  logic [5:0]  m_hsize,
    input  logic [3:0]  m_htrans,
    output logic [1:0]  m_grant,
    output logic [1:0]  m_hready,
    output logic [31:0] m_hrdata,
    output logic [31:0] s_haddr,
    output logic [31:0] s_hwdata,
    output logic        s_hwrite,
    output logic [2:0]  s_hsize,
    output logic [1:0]  s_htrans,
    input  logic        s_hready,
    input  logic [31:0] s_hrdata
);

    localparam logic       DEF_M     = (DEFAULT_MASTER != 0);
    localparam logic [8:0] CAP_LIMIT = 9'(MAX_BURST);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    logic       addr_owner_q, addr_owner_d;
    logic       data_owner_q, data_owner_d;
    logic       data_valid_q, data_valid_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] burst_cnt_q,  burst_cnt_d;

    logic [1:0] own_htrans;
    logic       own_req;
    logic       oth_req;
    logic       own_idle;
    logic       own_seq;
    logic       accepted;
    logic       cap_hit;
    logic       next_owner;
    logic       switch_owner;
    logic [8:0] beat_total;

    // Address/control path follows the address-phase owner.
    always_comb begin
        if (addr_owner_q) begin
            s_haddr    = m_haddr[63:32];
            s_hwrite   = m_hwrite[1];
            s_hsize    = m_hsize[5:3];
            own_htrans = m_htrans[3:2];
        end else begin
            s_haddr    = m_haddr[31:0];
            s_hwrite   = m_hwrite[0];
            s_hsize    = m_hsize[2:0];
            own_htrans = m_htrans[1:0];
        end
        // Reset kills any in-flight transfer at once, without waiting for an edge.
        s_htrans = reset ? HT_IDLE : own_htrans;
    end

    // Write data follows the data-phase owner and is zero when no data phase is open.
    always_comb begin
        if (!data_valid_q) begin
            s_hwdata = '0;
        end else if (data_owner_q) begin
            s_hwdata = m_hwdata[63:32];
        end else begin
            s_hwdata = m_hwdata[31:0];
        end
    end

    assign m_hrdata = s_hrdata;
    assign m_grant  = addr_owner_q ? 2'b10 : 2'b01;

    // A master gets HREADY if it owns the address phase or the open data phase.
    always_comb begin
        m_hready[0] = s_hready && !reset &&
                      (!addr_owner_q || (data_valid_q && !data_owner_q));
        m_hready[1] = s_hready && !reset &&
                      (addr_owner_q || (data_valid_q && data_owner_q));
    end

    // Arbitration and next-state logic.
    always_comb begin
        own_req    = m_req[addr_owner_q];
        oth_req    = m_req[~addr_owner_q];
        own_idle   = (own_htrans == HT_IDLE);
        own_seq    = (own_htrans == HT_SEQ);
        accepted   = s_hready && s_htrans[1];
        // The beat accepted on this edge counts toward the cap.
        beat_total = {1'b0, burst_cnt_q} + {8'd0, accepted};
        cap_hit    = (beat_total >= CAP_LIMIT);

        next_owner = addr_owner_q;
        if (own_req && oth_req) begin
            // An idle owner hands over round-robin. A busy owner hands over only at the cap.
            if (own_idle) begin
                next_owner = ~last_grant_q;
            end else if (cap_hit) begin
                next_owner = ~addr_owner_q;
            end
        end else if (oth_req) begin
            next_owner = ~addr_owner_q;
        end else if (!own_req) begin
            next_owner = DEF_M;
        end
        // A SEQ beat is never cut off unless the burst cap forces it.
        if (own_seq && !cap_hit) begin
            next_owner = addr_owner_q;
        end
        // Ownership is frozen across slave wait states.
        if (!s_hready) begin
            next_owner = addr_owner_q;
        end

        switch_owner = (next_owner != addr_owner_q);
        addr_owner_d = next_owner;
        last_grant_d = switch_owner ? next_owner : last_grant_q;

        if (switch_owner) begin
            burst_cnt_d = 8'd0;
        end else if (accepted && (burst_cnt_q != 8'hFF)) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end

        data_owner_d = accepted ? addr_owner_q : data_owner_q;
        if (accepted) begin
            data_valid_d = 1'b1;
        end else if (s_hready) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            addr_owner_q <= DEF_M;
            data_owner_q <= DEF_M;
            data_valid_q <= 1'b0;
            last_grant_q <= DEF_M;
            burst_cnt_q  <= 8'd0;
        end else begin
            addr_owner_q <= addr_owner_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_arbiter.sv
`timescale 1ns/1ps
module tb_mfp_ahb_arbiter;

    localparam int MAX_BURST = 16;
    localparam int DEF_M     = 0;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic clk_in = 1'b0;
    logic reset;

    logic        tb_req   [2];
    logic [31:0] tb_addr  [2];
    logic [31:0] tb_wdata [2];
    logic        tb_write [2];
    logic [2:0]  tb_size  [2];
    logic [1:0]  tb_trans [2];

    logic [1:0]  m_req;
    logic [63:0] m_haddr;
    logic [63:0] m_hwdata;
    logic [1:0]  m_hwrite;
    logic [5:0]  m_hsize;
    logic [3:0]  m_htrans;
    logic [1:0]  m_grant;
    logic [1:0]  m_hready;
    logic [31:0] m_hrdata;
    logic [31:0] s_haddr;
    logic [31:0] s_hwdata;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [1:0]  s_htrans;
    logic        s_hready;
    logic [31:0] s_hrdata;

    assign m_req    = {tb_req[1], tb_req[0]};
    assign m_haddr  = {tb_addr[1], tb_addr[0]};
    assign m_hwdata = {tb_wdata[1], tb_wdata[0]};
    assign m_hwrite = {tb_write[1], tb_write[0]};
    assign m_hsize  = {tb_size[1], tb_size[0]};
    assign m_htrans = {tb_trans[1], tb_trans[0]};

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the address phase, who owns the open data phase.
    int mo_addr;
    int mo_down;
    int mo_cnt;
    int mo_last;
    bit mo_dv;

    mfp_ahb_arbiter #(.MAX_BURST(MAX_BURST), .DEFAULT_MASTER(DEF_M)) dut (
        .clk_in(clk_in), .reset(reset),
        .m_req(m_req), .m_haddr(m_haddr), .m_hwdata(m_hwdata),
        .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_htrans(m_htrans),
        .m_grant(m_grant), .m_hready(m_hready), .m_hrdata(m_hrdata),
        .s_haddr(s_haddr), .s_hwdata(s_hwdata), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_htrans(s_htrans),
        .s_hready(s_hready), .s_hrdata(s_hrdata)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        mo_addr = DEF_M;
        mo_last = DEF_M;
        mo_down = DEF_M;
        mo_dv   = 1'b0;
        mo_cnt  = 0;
    endtask

    task automatic model_edge();
        int  own;
        int  oth;
        int  nxt;
        bit  acc;
        bit  cap;
        if (reset) begin
            model_reset();
            return;
        end
        own = mo_addr;
        oth = 1 - own;
        acc = s_hready && (tb_trans[own] == NONSEQ || tb_trans[own] == SEQ);
        cap = (mo_cnt + (acc ? 1 : 0)) >= MAX_BURST;
        nxt = own;
        if (s_hready) begin
            if (tb_req[own] && tb_req[oth]) begin
                if (tb_trans[own] == IDLE) nxt = 1 - mo_last;
                else if (cap) nxt = oth;
            end else if (tb_req[oth]) begin
                nxt = oth;
            end else if (!tb_req[own]) begin
                nxt = DEF_M;
            end
            if (tb_trans[own] == SEQ && !cap) nxt = own;
        end
        if (acc) begin
            mo_dv   = 1'b1;
            mo_down = own;
        end else if (s_hready) begin
            mo_dv = 1'b0;
        end
        if (nxt != own) begin
            mo_cnt  = 0;
            mo_last = nxt;
            mo_addr = nxt;
        end else if (acc && mo_cnt < 255) begin
            mo_cnt = mo_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic idle_bus(input int n);
        for (int i = 0; i < 2; i++) begin
            tb_req[i]   = 1'b0;
            tb_trans[i] = IDLE;
        end
        s_hready = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        s_hready    = 1'b1;
        tb_req[0]   = 1'b1;
        tb_trans[0] = NONSEQ;
        tb_addr[0]  = 32'h8000_0000;
        tick();
        #1;
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL reset_grant: got %b want 01", m_grant); end
        checks++; if (s_htrans !== IDLE) begin failures++; $display("FAIL reset_htrans: got %b want 00", s_htrans); end
        checks++; if (m_hready !== 2'b00) begin failures++; $display("FAIL reset_hready: got %b want 00", m_hready); end
        tick();
        reset = 1'b0;
        tb_write[0] = 1'b1;
        #1;
        checks++; if (s_htrans !== NONSEQ) begin failures++; $display("FAIL first_nonseq: got %b want 10", s_htrans); end
        tick();
        tb_trans[0] = SEQ;
        tb_addr[0]  = 32'h8000_0004;
        tb_wdata[0] = $urandom;
        #1;
        checks++; if (s_hwdata !== tb_wdata[0]) begin failures++; $display("FAIL burst_wdata: got %h want %h", s_hwdata, tb_wdata[0]); end
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (s_htrans !== IDLE) begin failures++; $display("FAIL async_htrans: got %b want 00", s_htrans); end
        checks++; if (s_hwdata !== 32'h0) begin failures++; $display("FAIL async_wdata: got %h want 0", s_hwdata); end
        checks++; if (m_grant !== 2'b01 || m_hready !== 2'b00) begin failures++; $display("FAIL async_grant_rdy: got %b/%b want 01/00", m_grant, m_hready); end
        tick();
        reset = 1'b0;
        tb_trans[0] = NONSEQ;
        tb_addr[0]  = 32'hBFC0_0000;
        #2;
        checks++; if (s_hwdata !== 32'h0) begin failures++; $display("FAIL post_rst_no_data: got %h want 0", s_hwdata); end
        checks++; if (s_haddr !== 32'hBFC0_0000 || s_htrans !== NONSEQ) begin failures++; $display("FAIL post_rst_addr: got %h/%b want bfc00000/10", s_haddr, s_htrans); end
        tick();
        tb_trans[0] = IDLE;
        tb_wdata[0] = $urandom;
        #2;
        checks++; if (s_hwdata !== tb_wdata[0] || m_hready !== 2'b01) begin failures++; $display("FAIL post_rst_data: got %h/%b want %h/01", s_hwdata, m_hready, tb_wdata[0]); end
        idle_bus(2);
    endtask

    task automatic test_single_write();
        tb_req[0] = 1'b1;  tb_req[1] = 1'b0;  tb_trans[1] = IDLE;
        tb_addr[0] = 32'hBF80_0000; tb_write[0] = 1'b1; tb_size[0] = 3'b010;
        tb_trans[0] = NONSEQ; tb_wdata[0] = $urandom; s_hready = 1'b1;
        #2;
        checks++; if (s_haddr !== 32'hBF80_0000 || s_hwrite !== 1'b1 || s_htrans !== NONSEQ) begin failures++; $display("FAIL sw_addr: got %h/%b/%b want bf800000/1/10", s_haddr, s_hwrite, s_htrans); end
        checks++; if (m_hready[1] !== 1'b0) begin failures++; $display("FAIL sw_rdy1_a: got %b want 0", m_hready[1]); end
        tick();
        tb_trans[0] = IDLE;
        tb_wdata[0] = 32'h0000_00A5;
        tb_addr[0]  = $urandom;
        #2;
        checks++; if (s_hwdata !== 32'h0000_00A5) begin failures++; $display("FAIL sw_wdata: got %h want 000000a5", s_hwdata); end
        checks++; if (m_hready !== 2'b01 || m_grant !== 2'b01) begin failures++; $display("FAIL sw_rdy_grant: got %b/%b want 01/01", m_hready, m_grant); end
        tick();
        #2;
        checks++; if (s_hwdata !== 32'h0) begin failures++; $display("FAIL sw_wdata_closed: got %h want 0", s_hwdata); end
        idle_bus(2);
    endtask

    task automatic test_round_robin();
        int own;
        tb_req[0] = 1'b1; tb_req[1] = 1'b1;
        tb_trans[0] = IDLE; tb_trans[1] = IDLE;
        #2;
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL rr_park: got %b want 01", m_grant); end
        tick();
        own = 1;
        for (int k = 0; k < 6; k++) begin
            tb_trans[own]     = NONSEQ;
            tb_addr[own]      = $urandom;
            tb_trans[1 - own] = NONSEQ;
            #2;
            checks++; if (m_grant !== ((own == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant_k%0d: got %b want owner %0d", k, m_grant, own); end
            checks++; if (m_hready[1 - own] !== 1'b0 || s_haddr !== tb_addr[own]) begin failures++; $display("FAIL rr_stall_k%0d: got %b/%h want 0/%h", k, m_hready[1 - own], s_haddr, tb_addr[own]); end
            tick();
            tb_trans[own] = IDLE;
            #2;
            checks++; if (m_grant !== ((own == 1) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_hold_k%0d: got %b want owner %0d", k, m_grant, own); end
            tick();
            own = 1 - own;
        end
        tb_req[0] = 1'b0; tb_req[1] = 1'b0;
        tb_trans[0] = IDLE; tb_trans[1] = IDLE;
        tick();
        #2;
        checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL rr_repark: got %b want 01", m_grant); end
        idle_bus(2);
    endtask

    task automatic test_burst_cap();
        logic [31:0] base;
        int beats;
        int n;
        base  = 32'h8000_1000;
        beats = 0;
        n     = 0;
        tb_req[0] = 1'b1; tb_req[1] = 1'b1;
        tb_trans[1] = NONSEQ; tb_addr[1] = 32'h8000_2000; tb_write[1] = 1'b0;
        tb_write[0] = 1'b1; s_hready = 1'b1;
        while (m_grant == 2'b01 && n < 40) begin
            tb_trans[0] = (beats == 0) ? NONSEQ : SEQ;
            tb_addr[0]  = base + 32'(4 * beats);
            tb_wdata[0] = $urandom;
            #2;
            checks++; if (s_haddr !== base + 32'(4 * beats)) begin failures++; $display("FAIL cap_addr_b%0d: got %h want %h", beats, s_haddr, base + 32'(4 * beats)); end
            if (m_hready[0] && m_grant[0]) beats++;
            tick();
            n++;
        end
        checks++; if (n >= 40) begin failures++; $display("FAIL cap_timeout: grant never left m0 after %0d cycles", n); end
        checks++; if (beats !== 16) begin failures++; $display("FAIL cap_beats: got %0d want 16", beats); end
        tb_trans[0] = SEQ;
        tb_addr[0]  = base + 32'(4 * beats);
        #2;
        checks++; if (m_grant !== 2'b10 || s_haddr !== 32'h8000_2000) begin failures++; $display("FAIL cap_handover: got %b/%h want 10/80002000", m_grant, s_haddr); end
        checks++; if (m_hready !== 2'b11) begin failures++; $display("FAIL cap_overlap_rdy: got %b want 11", m_hready); end
        tick();
        tb_trans[1] = IDLE;
        #2;
        checks++; if (m_hready[0] !== 1'b0) begin failures++; $display("FAIL cap_m0_stall: got %b want 0", m_hready[0]); end
        tick();
        for (int b = 16; b < 20; b++) begin
            tb_addr[0] = base + 32'(4 * b);
            tb_trans[0] = SEQ;
            #2;
            checks++; if (m_grant !== 2'b01 || m_hready[0] !== 1'b1 || s_haddr !== tb_addr[0]) begin failures++; $display("FAIL cap_resume_b%0d: got %b/%b/%h want 01/1/%h", b, m_grant, m_hready[0], s_haddr, tb_addr[0]); end
            tick();
        end
        idle_bus(3);
    endtask

    task automatic test_wait_states();
        tb_req[0] = 1'b1; tb_req[1] = 1'b0; tb_trans[1] = IDLE;
        tb_trans[0] = NONSEQ; tb_write[0] = 1'b0; tb_addr[0] = 32'h8000_0040;
        s_hready = 1'b1;
        #2;
        checks++; if (m_hready[0] !== 1'b1) begin failures++; $display("FAIL ws_addr_rdy: got %b want 1", m_hready[0]); end
        tick();
        tb_trans[0] = IDLE;
        tb_req[1] = 1'b1; tb_trans[1] = NONSEQ; tb_addr[1] = 32'h8000_0300;
        s_hready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            #2;
            checks++; if (m_grant !== 2'b01) begin failures++; $display("FAIL ws_grant_w%0d: got %b want 01", w, m_grant); end
            checks++; if (m_hready !== 2'b00) begin failures++; $display("FAIL ws_rdy_w%0d: got %b want 00", w, m_hready); end
            tick();
        end
        s_hready = 1'b1;
        s_hrdata = 32'h1234_5678;
        #2;
        checks++; if (m_hready !== 2'b01 || m_hrdata !== 32'h1234_5678) begin failures++; $display("FAIL ws_rdata: got %b/%h want 01/12345678", m_hready, m_hrdata); end
        tick();
        #2;
        checks++; if (m_grant !== 2'b10) begin failures++; $display("FAIL ws_switch: got %b want 10", m_grant); end
        idle_bus(3);
    endtask

    task automatic test_handover();
        logic [31:0] w0;
        logic [31:0] rd;
        tb_req[0] = 1'b0; tb_req[1] = 1'b1;
        tb_trans[0] = NONSEQ; tb_write[0] = 1'b1; tb_addr[0] = 32'hBF80_0010;
        tb_trans[1] = NONSEQ; tb_write[1] = 1'b0; tb_addr[1] = 32'h8000_0100;
        s_hready = 1'b1;
        #2;
        checks++; if (s_haddr !== 32'hBF80_0010 || m_grant !== 2'b01) begin failures++; $display("FAIL ho_m0_addr: got %h/%b want bf800010/01", s_haddr, m_grant); end
        tick();
        w0 = $urandom;
        tb_trans[0] = IDLE; tb_wdata[0] = w0; tb_wdata[1] = $urandom;
        #2;
        checks++; if (s_haddr !== 32'h8000_0100 || s_hwrite !== 1'b0 || m_grant !== 2'b10) begin failures++; $display("FAIL ho_m1_addr: got %h/%b/%b want 80000100/0/10", s_haddr, s_hwrite, m_grant); end
        checks++; if (s_hwdata !== w0 || m_hready !== 2'b11) begin failures++; $display("FAIL ho_m0_data: got %h/%b want %h/11", s_hwdata, m_hready, w0); end
        tick();
        rd = $urandom;
        tb_trans[1] = IDLE; s_hrdata = rd;
        #2;
        checks++; if (m_hrdata !== rd || m_hready !== 2'b10 || s_hwdata !== tb_wdata[1]) begin failures++; $display("FAIL ho_m1_data: got %h/%b/%h want %h/10/%h", m_hrdata, m_hready, s_hwdata, rd, tb_wdata[1]); end
        idle_bus(3);
    endtask

    task automatic test_random();
        logic [1:0]  exp_grant;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_wdata;
        logic [37:0] exp_ctl;
        logic [37:0] got_ctl;
        for (int c = 0; c < 600; c++) begin
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 79) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            for (int i = 0; i < 2; i++) begin
                tb_req[i] = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0, 1:    tb_trans[i] = IDLE;
                    2:       tb_trans[i] = BUSY;
                    3, 4:    tb_trans[i] = NONSEQ;
                    default: tb_trans[i] = SEQ;
                endcase
                tb_addr[i]  = $urandom;
                tb_wdata[i] = $urandom;
                tb_write[i] = 1'($urandom_range(0, 1));
                tb_size[i]  = 3'($urandom_range(0, 7));
            end
            s_hready = ($urandom_range(0, 3) != 0);
            s_hrdata = $urandom;
            #2;
            exp_grant = (mo_addr == 1) ? 2'b10 : 2'b01;
            for (int i = 0; i < 2; i++)
                exp_rdy[i] = !reset && s_hready && (mo_addr == i || (mo_dv && mo_down == i));
            exp_wdata = mo_dv ? tb_wdata[mo_down] : 32'h0;
            exp_ctl   = {tb_addr[mo_addr], (reset ? IDLE : tb_trans[mo_addr]), tb_write[mo_addr], tb_size[mo_addr]};
            got_ctl   = {s_haddr, s_htrans, s_hwrite, s_hsize};
            checks++; if (m_grant !== exp_grant) begin failures++; $display("FAIL rnd_grant_c%0d: got %b want %b", c, m_grant, exp_grant); end
            checks++; if (m_hready !== exp_rdy) begin failures++; $display("FAIL rnd_hready_c%0d: got %b want %b", c, m_hready, exp_rdy); end
            checks++; if (got_ctl !== exp_ctl) begin failures++; $display("FAIL rnd_addrctl_c%0d: got %h want %h", c, got_ctl, exp_ctl); end
            checks++; if (s_hwdata !== exp_wdata) begin failures++; $display("FAIL rnd_hwdata_c%0d: got %h want %h", c, s_hwdata, exp_wdata); end
            checks++; if (m_hrdata !== s_hrdata) begin failures++; $display("FAIL rnd_hrdata_c%0d: got %h want %h", c, m_hrdata, s_hrdata); end
            tick();
        end
        reset = 1'b0;
        idle_bus(2);
    endtask

    initial begin
        reset    = 1'b1;
        s_hready = 1'b1;
        s_hrdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            tb_req[i]   = 1'b0;
            tb_addr[i]  = 32'h0;
            tb_wdata[i] = 32'h0;
            tb_write[i] = 1'b0;
            tb_size[i]  = 3'b010;
            tb_trans[i] = IDLE;
        end
        model_reset();
        test_reset();
        test_single_write();
        test_round_robin();
        test_burst_cap();
        test_wait_states();
        test_handover();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfp_ahb_arbiter.md
Name: mfp_ahb_arbiter

Overview:
- Two-master AHB-Lite arbiter that shares the single AHB-Lite slave path (memory + GPIO/Rojobot decode) between the MIPS core (master 0) and a secondary bus master (master 1, e.g. a DMA/loader engine).
- Tracks the address-phase owner and the data-phase owner separately. Ownership handover is pipelined: the outgoing master's data phase overlaps the incoming master's address phase.
- Round-robin arbitration, with a burst cap that forces re-arbitration.

Parameters:
- MAX_BURST, 16: maximum consecutive accepted transfers by one owner while the other master is requesting. Range 1..255.
- DEFAULT_MASTER, 0: master parked on the bus after reset and when no master requests.

Ports:
- clk_in  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- m_req  input  2  per-master bus request; bit i = master i.
- m_haddr  input  64  master addresses, {m1[31:0], m0[31:0]}.
- m_hwdata  input  64  master write data, same packing.
- m_hwrite  input  2  per-master HWRITE.
- m_hsize  input  6  per-master HSIZE, {m1[2:0], m0[2:0]}.
- m_htrans  input  4  per-master HTRANS, {m1[1:0], m0[1:0]}.
- m_grant  output  2  one-hot address-phase ownership.
- m_hready  output  2  per-master HREADY.
- m_hrdata  output  32  read data, broadcast to both masters.
- s_haddr  output  32  muxed address to the slave path.
- s_hwdata  output  32  muxed write data.
- s_hwrite  output  1  muxed HWRITE.
- s_hsize  output  3  muxed HSIZE.
- s_htrans  output  2  muxed HTRANS.
- s_hready  input  1  slave-path HREADY.
- s_hrdata  input  32  slave-path read data.

Behaviour:
- Registered state:
  - addr_owner (1 bit)
  - data_owner (1 bit)
  - data_valid (1 bit)
  - last_grant (1 bit)
  - burst_cnt (8 bits)
- Reset values: addr_owner = last_grant = DEFAULT_MASTER; data_valid = 0; burst_cnt = 0.
- Reset-dependent outputs: m_grant = one-hot(DEFAULT_MASTER). While reset is high, s_htrans is forced to 2'b00 (IDLE) and m_hready = 2'b00.
- Address mux: s_haddr, s_hwrite, s_hsize and s_htrans come combinationally from addr_owner.
- Write-data mux: s_hwdata comes from data_owner. It is 0 when data_valid = 0.
- m_hrdata = s_hrdata at all times.
- m_hready[i] = s_hready when i == addr_owner, or when (data_valid and i == data_owner). Otherwise 0, which stalls the non-owning master with its address held.
- Accepted transfer: s_hready = 1 and s_htrans[1] = 1 at a rising edge. On that edge data_owner <= addr_owner and data_valid <= 1. When s_hready = 1 with no accepted transfer, data_valid <= 0.
- burst_cnt:
  - Increments on each accepted transfer and saturates at 255.
  - Clears to 0 on any change of addr_owner.
- Re-arbitration happens only on edges with s_hready = 1. There is no switch during wait states, even if requests change. The next owner is chosen by these rules, in order:
  - Both m_req set: switch to the other master when burst_cnt + accepted >= MAX_BURST, or when the owner's m_htrans is IDLE; otherwise keep the owner.
  - Only the other master requesting: switch when the owner's m_htrans is IDLE, or when the owner's m_req = 0.
  - Owner requesting alone: keep the owner.
  - No request: park on DEFAULT_MASTER.
  - Never switch while the owner presents SEQ (2'b11) unless the burst cap has been reached.
- Switch latency: the new owner's m_grant bit rises on the edge where s_hready = 1. Its address phase is driven in the next cycle. The old owner's pending data phase completes in that same cycle via data_owner.
- On every switch, last_grant <= new owner.
- Simultaneous first requests from the parked/idle state: grant the master != last_grant (round-robin).
- m_grant is always exactly one-hot, including across reset.
- Asynchronous reset mid-transfer: the in-flight transfer is abandoned. The slave path sees IDLE immediately, and no data phase is tracked after release.

Test Plan:
- Reset asserted mid-burst by m0, then released → m_grant = 01, s_htrans = 00 during reset, data_valid = 0; the first post-reset NONSEQ from m0 passes through the next cycle.
- m0 single write to 0xBF80_0000 (data 0x0000_00A5) while m1 is idle → s_haddr = 0xBF80_0000 in cycle N, s_hwdata = 0xA5 in cycle N+1, m_hready[1] = 0 throughout.
- m0 and m1 both request from park → grant goes to the non-last_grant master; after that master's first IDLE, the grant alternates; m_grant never shows 00 or 11.
- m0 issues an 20-beat SEQ burst while m1 requests continuously, MAX_BURST = 16 → grant moves to m1 after exactly 16 accepted m0 beats; m0 stalls on hready = 0 until it regains the grant.
- Slave inserts 3 wait states (s_hready = 0) during an m0 read while m1 raises m_req → no grant change until s_hready = 1; m0 receives s_hrdata = 0x1234_5678 with correct m_hready[0] timing.
- Handover overlap: m0 write data phase and m1 read address phase occur in the same cycle → s_hwdata comes from m0 and s_haddr comes from m1 in that cycle.
